// File: rtl/ascon_aead128_pkg.sv
// Shared Ascon AEAD-128 types and constants: round value type, counter modes,
// and the permutation sequencer state set.
package ascon_aead128_pkg;

    typedef logic [3:0] round;

    localparam logic P12_MODE = 1'b0;
    localparam logic P8_MODE  = 1'b1;
    localparam logic NO_INCR  = 1'b0;
    localparam logic DO_INCR  = 1'b1;

    localparam round P12_INIT      = 4'h4;
    localparam round P8_INIT       = 4'h8;
    localparam round ROUND_LAST    = 4'hF;
    localparam round P8_ALIGN_LAST = 4'h7;

    localparam int unsigned PERM_LATENCY = 13;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        RUN,
        DONE,
        FLUSH
    } perm_state;

    function automatic round round_init(input logic mode);
        return (mode == P8_MODE) ? P8_INIT : P12_INIT;
    endfunction

endpackage

// File: rtl/permutation_ctrl_if.sv
// Request/round bus between the AEAD FSM (master) and the permutation sequencer (slave).
// The abort signal exists only when PERM_ABORT_EN is defined.
interface permutation_ctrl_if;

    logic                      start;
    logic                      mode;
    logic                      ready;
    logic                      round_en;
    ascon_aead128_pkg::round   rnd;
    logic                      done;
`ifdef PERM_ABORT_EN
    logic                      abort;

    modport master (output start, mode, abort, input ready, round_en, rnd, done);
    modport slave  (input start, mode, abort, output ready, round_en, rnd, done);
`else
    modport master (output start, mode, input ready, round_en, rnd, done);
    modport slave  (input start, mode, output ready, round_en, rnd, done);
`endif

endinterface

// File: rtl/permutation_ctrl_round_counter.sv
// Ascon round counter: steps towards 4'hF and wraps to the mode's initial round.
module round_counter
    import ascon_aead128_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic mode_i,
    input  logic incr_i,
    output round rnd_o
);

    round rnd_q, rnd_d;

    always_comb begin
        rnd_d = rnd_q;
        if (incr_i == DO_INCR) begin
            rnd_d = (rnd_q == ROUND_LAST) ? round_init(mode_i) : rnd_q + 4'h1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_q <= round_init(mode_i);
        end else begin
            rnd_q <= rnd_d;
        end
    end

    assign rnd_o = rnd_q;

endmodule

// File: rtl/permutation_ctrl.sv
// Constant-time Ascon permutation sequencer: P8 and P12 both take 13 cycles.
// Define PERM_ABORT_EN to add the abort input and the FLUSH state.
module permutation_ctrl
    import ascon_aead128_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    permutation_ctrl_if.slave  perm
);

    perm_state state_q, state_d;
    logic      mode_q, mode_d;
    logic      ready_q, round_en_q, done_q;
    logic      incr;
    round      rnd;

    // Counter always runs the full P12 schedule; P8 skips rounds 4..7 in ALIGN.
    round_counter u_round_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .mode_i (P12_MODE),
        .incr_i (incr),
        .rnd_o  (rnd)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        incr    = NO_INCR;
        unique case (state_q)
            IDLE: begin
                if (perm.start) begin
                    mode_d  = perm.mode;
                    state_d = (perm.mode == P8_MODE) ? ALIGN : RUN;
                end
            end
            ALIGN: begin
                incr = DO_INCR;
                if (rnd == P8_ALIGN_LAST) state_d = RUN;
            end
            RUN: begin
                incr = DO_INCR;
                if (rnd == ROUND_LAST) state_d = DONE;
            end
            DONE: state_d = IDLE;
`ifdef PERM_ABORT_EN
            // Spin the counter back to rest, then hold one cycle so the abort path
            // returns to IDLE on the same cycle as a completed permutation.
            FLUSH: begin
                if (rnd == P12_INIT) state_d = IDLE;
                else                 incr    = DO_INCR;
            end
`endif
            default: state_d = IDLE;
        endcase
`ifdef PERM_ABORT_EN
        if (perm.abort && (state_q == ALIGN || state_q == RUN)) state_d = FLUSH;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= P12_MODE;
            ready_q    <= 1'b1;
            round_en_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            ready_q    <= (state_d == IDLE);
            round_en_q <= (state_d == RUN);
            done_q     <= (state_d == DONE);
        end
    end

    assign perm.ready    = ready_q;
    assign perm.round_en = round_en_q;
    assign perm.rnd      = rnd;
    assign perm.done     = done_q;

    a_idle_at_rest: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == IDLE) |-> (rnd == P12_INIT));

    a_align_only_p8: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ALIGN) |-> (mode_q == P8_MODE));

endmodule
